// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types: word type, PC-select and fetch FSM encodings, fetch tag.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4  = 2'd0,
    PC_SEL_JALR   = 2'd1,
    PC_SEL_BRANCH = 2'd2,
    PC_SEL_JAL    = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fe_state_e;

  // One issued fetch: the address it was issued from and whether it is live.
  typedef struct packed {
    word_t pc;
    logic  valid;
  } fetch_tag_t;

  // Instruction fetches are word aligned; drop the byte offset.
  function automatic word_t word_align(input word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer parking an instruction that returned while decode was stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clr,
  input  logic [31:0] ld_data,
  input  logic [31:0] ld_pc,
  output logic [31:0] data,
  output logic [31:0] pc,
  output logic        valid
);

  word_t data_q;
  word_t pc_q;
  logic  valid_q;

  // Clear wins over load so a redirect squashes a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= ld_data;
      pc_q    <= ld_pc;
      valid_q <= 1'b1;
    end
  end

  assign data  = data_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, one-deep in-flight tag, IF/DE register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        FE_CLK,
  input  logic        FE_RST,
  input  logic        STALL,
  input  logic [1:0]  PC_SEL,
  input  logic [31:0] JALR_TGT,
  input  logic [31:0] BRANCH_TGT,
  input  logic [31:0] JAL_TGT,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_RDEN,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] IR,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS4,
  output logic        IR_VALID
);

  localparam word_t INSTR_BYTES = 32'd4;

  fe_state_e  state_q, state_d;
  word_t      pc_q, pc_d;
  fetch_tag_t tag_q, tag_d;
  word_t      ir_q, ir_d;
  word_t      pc_out_q, pc_out_d;
  word_t      pc_plus4_q, pc_plus4_d;
  logic       ir_valid_q, ir_valid_d;

  pc_sel_e    sel_c;
  logic       redirect_c;
  logic       rden_c;
  word_t      tgt_c;
  logic       hb_load_c;
  logic       hb_clr_c;
  word_t      hb_data;
  word_t      hb_pc;
  logic       hb_valid;

  assign sel_c      = pc_sel_e'(PC_SEL);
  assign redirect_c = (sel_c != PC_SEL_PLUS4);
  assign rden_c     = !FE_RST && ((state_q == ST_BOOT) || ((state_q == ST_RUN) && !STALL));

  // Redirect target selection.
  always_comb begin
    tgt_c = JAL_TGT;
    case (sel_c)
      PC_SEL_JALR:   tgt_c = JALR_TGT;
      PC_SEL_BRANCH: tgt_c = BRANCH_TGT;
      default:       tgt_c = JAL_TGT;
    endcase
  end

  fetch_hold_buf u_hold_buf (
    .clk     (FE_CLK),
    .rst     (FE_RST),
    .load    (hb_load_c),
    .clr     (hb_clr_c),
    .ld_data (IMEM_DATA),
    .ld_pc   (tag_q.pc),
    .data    (hb_data),
    .pc      (hb_pc),
    .valid   (hb_valid)
  );

  // Next state and next register values; redirect overrides stall and state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tag_d.pc    = pc_q;
    tag_d.valid = rden_c;
    ir_d        = ir_q;
    pc_out_d    = pc_out_q;
    ir_valid_d  = ir_valid_q;
    hb_load_c   = 1'b0;
    hb_clr_c    = 1'b0;

    if (redirect_c) begin
      pc_d        = word_align(tgt_c);
      tag_d.valid = 1'b0;
      hb_clr_c    = 1'b1;
      ir_d        = NOP_INSTR;
      ir_valid_d  = 1'b0;
      state_d     = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: begin
          pc_d       = pc_q + INSTR_BYTES;
          ir_d       = NOP_INSTR;
          ir_valid_d = 1'b0;
          state_d    = ST_RUN;
        end
        ST_RUN: begin
          if (!STALL) begin
            pc_d       = pc_q + INSTR_BYTES;
            ir_d       = tag_q.valid ? IMEM_DATA : NOP_INSTR;
            pc_out_d   = tag_q.pc;
            ir_valid_d = tag_q.valid;
          end else if (tag_q.valid) begin
            hb_load_c = 1'b1;
            state_d   = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!STALL) begin
            ir_d       = hb_valid ? hb_data : NOP_INSTR;
            pc_out_d   = hb_pc;
            ir_valid_d = hb_valid;
            hb_clr_c   = 1'b1;
            state_d    = ST_RUN;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end

    pc_plus4_d = pc_out_d + INSTR_BYTES;
  end

  // FSM state register.
  always_ff @(posedge FE_CLK) begin
    if (FE_RST) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, in-flight tag and IF/DE registers.
  always_ff @(posedge FE_CLK) begin
    if (FE_RST) begin
      pc_q       <= RESET_VEC;
      tag_q      <= '0;
      ir_q       <= NOP_INSTR;
      pc_out_q   <= '0;
      pc_plus4_q <= INSTR_BYTES;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      ir_q       <= ir_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign IMEM_ADDR = pc_q;
  assign IMEM_RDEN = rden_c;
  assign IR        = ir_q;
  assign PC_OUT    = pc_out_q;
  assign PC_PLUS4  = pc_plus4_q;
  assign IR_VALID  = ir_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized stream-order model.
module tb_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] WRAP_VEC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [31:0] jalr_tgt, branch_tgt, jal_tgt;
  logic [31:0] imem_addr, imem_data, ir, pc_out, pc_plus4;
  logic        imem_rden, ir_valid;

  logic [31:0] w_addr, w_data, w_ir, w_pc_out, w_pc_plus4;
  logic        w_rden, w_ir_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .FE_CLK(clk), .FE_RST(rst), .STALL(stall), .PC_SEL(pc_sel),
    .JALR_TGT(jalr_tgt), .BRANCH_TGT(branch_tgt), .JAL_TGT(jal_tgt),
    .IMEM_ADDR(imem_addr), .IMEM_RDEN(imem_rden), .IMEM_DATA(imem_data),
    .IR(ir), .PC_OUT(pc_out), .PC_PLUS4(pc_plus4), .IR_VALID(ir_valid)
  );

  fetch_stage #(.RESET_VEC(WRAP_VEC)) u_wrap (
    .FE_CLK(clk), .FE_RST(rst), .STALL(1'b0), .PC_SEL(2'b00),
    .JALR_TGT(32'h0), .BRANCH_TGT(32'h0), .JAL_TGT(32'h0),
    .IMEM_ADDR(w_addr), .IMEM_RDEN(w_rden), .IMEM_DATA(w_data),
    .IR(w_ir), .PC_OUT(w_pc_out), .PC_PLUS4(w_pc_plus4), .IR_VALID(w_ir_valid)
  );

  // Memory image: word k holds 0x100 + k.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  // One-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    imem_data <= imem_rden ? mem_word(imem_addr) : $urandom;
    w_data    <= w_rden ? mem_word(w_addr) : $urandom;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    stall = 1'b0; pc_sel = 2'd0;
    jalr_tgt = $urandom; branch_tgt = $urandom; jal_tgt = $urandom;
  endtask

  // Leaves the bench #1 into cycle 0, the first cycle after reset release.
  task automatic apply_reset();
    rst = 1'b1; drive_idle();
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_idle();
    tick(); tick();
    checks++; if (ir !== NOP) begin errors++; $display("FAIL reset_ir got %h want %h", ir, NOP); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ir_valid); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h want 0", pc_out); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h want 4", pc_plus4); end
    checks++; if (imem_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b want 0", imem_rden); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (w_addr !== WRAP_VEC) begin errors++; $display("FAIL reset_wrap_addr got %h want %h", w_addr, WRAP_VEC); end
  endtask

  task automatic test_boot_seq();
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        checks++; if (imem_addr !== 32'(4 * c)) begin errors++; $display("FAIL boot_addr c%0d got %h want %h", c, imem_addr, 32'(4 * c)); end
        checks++; if (imem_rden !== 1'b1) begin errors++; $display("FAIL boot_rden c%0d got %b want 1", c, imem_rden); end
      end
      if (c < 2) begin
        checks++; if (ir_valid !== 1'b0 || ir !== NOP) begin errors++; $display("FAIL boot_bubble c%0d got %b/%h want 0/%h", c, ir_valid, ir, NOP); end
      end else begin
        checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL boot_valid c%0d got %b want 1", c, ir_valid); end
        checks++; if (ir !== mem_word(32'(4 * (c - 2)))) begin errors++; $display("FAIL boot_ir c%0d got %h want %h", c, ir, mem_word(32'(4 * (c - 2)))); end
        checks++; if (pc_out !== 32'(4 * (c - 2))) begin errors++; $display("FAIL boot_pc_out c%0d got %h want %h", c, pc_out, 32'(4 * (c - 2))); end
        checks++; if (pc_plus4 !== 32'(4 * (c - 1))) begin errors++; $display("FAIL boot_pc_plus4 c%0d got %h want %h", c, pc_plus4, 32'(4 * (c - 1))); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] seen[$];
    apply_reset();
    tick(); tick(); tick();
    checks++; if (ir !== 32'h101) begin errors++; $display("FAIL stall_pre_ir got %h want 101", ir); end
    stall = 1'b1; #1;
    checks++; if (imem_rden !== 1'b0) begin errors++; $display("FAIL stall_rden_c3 got %b want 0", imem_rden); end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) begin stall = 1'b0; #1; end
      checks++; if (ir !== 32'h101 || pc_out !== 32'h4 || ir_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold k%0d got %h@%h v%b want 101@4 v1", k, ir, pc_out, ir_valid); end
      if (k < 2) begin
        checks++; if (imem_rden !== 1'b0) begin errors++; $display("FAIL stall_rden k%0d got %b want 0", k, imem_rden); end
      end
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ir_valid === 1'b1) seen.push_back(ir);
    end
    checks++; if (seen.size() < 3) begin errors++; $display("FAIL stall_count got %0d want >=3", seen.size()); end
    for (int k = 0; k < 3 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== 32'(32'h102 + k)) begin errors++; $display("FAIL stall_order k%0d got %h want %h", k, seen[k], 32'(32'h102 + k)); end
    end
  endtask

  task automatic test_redirect_jal();
    apply_reset();
    tick(); tick(); tick(); tick();
    // Redirect is presented in cycle 4 and takes effect at the edge opening cycle 5.
    pc_sel = 2'd3; jal_tgt = 32'h40;
    tick();
    drive_idle(); #1;
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL jal_addr got %h want 40", imem_addr); end
    for (int c = 5; c < 9; c++) begin
      if (c < 7) begin
        checks++; if (ir_valid !== 1'b0 || ir !== NOP) begin errors++; $display("FAIL jal_bubble c%0d got %b/%h want 0/%h", c, ir_valid, ir, NOP); end
      end else begin
        checks++; if (ir_valid !== 1'b1 || ir !== 32'(32'h110 + c - 7) || pc_out !== 32'(32'h40 + 4 * (c - 7))) begin
          errors++; $display("FAIL jal_target c%0d got %h@%h v%b want %h@%h v1", c, ir, pc_out, ir_valid, 32'(32'h110 + c - 7), 32'(32'h40 + 4 * (c - 7))); end
      end
      if (c == 8) begin pc_sel = 2'd1; jalr_tgt = 32'h203; end
      tick();
      if (c == 8) drive_idle();
    end
    // Misaligned JALR target 0x203 fetches from 0x200 (word 0x80).
    for (int c = 9; c < 12; c++) begin
      if (c < 11) begin
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL jalr_bubble c%0d got %b want 0", c, ir_valid); end
      end else begin
        checks++; if (ir !== 32'h180 || pc_out !== 32'h200 || ir_valid !== 1'b1) begin
          errors++; $display("FAIL jalr_target got %h@%h v%b want 180@200 v1", ir, pc_out, ir_valid); end
      end
      tick();
    end
  endtask

  task automatic test_hold_redirect();
    logic        exp_v[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_ir[5] = '{NOP, NOP, 32'h120, 32'h121, 32'h122};
    apply_reset();
    tick(); tick(); tick();
    stall = 1'b1;
    tick();
    pc_sel = 2'd2; branch_tgt = 32'h82;
    tick();
    drive_idle(); #1;
    checks++; if (imem_addr !== 32'h80 || imem_rden !== 1'b1) begin errors++; $display("FAIL hold_br_fetch got %h r%b want 80 r1", imem_addr, imem_rden); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (ir_valid !== exp_v[c] || ir !== exp_ir[c]) begin
        errors++; $display("FAIL hold_br_seq c%0d got %h v%b want %h v%b", c + 5, ir, ir_valid, exp_ir[c], exp_v[c]); end
      tick();
    end
  endtask

  task automatic test_reset_in_hold();
    logic        exp_v[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_ir[5] = '{NOP, NOP, 32'h100, 32'h101, 32'h102};
    apply_reset();
    tick(); tick(); tick();
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h0 || ir_valid !== 1'b0 || imem_rden !== 1'b0) begin
      errors++; $display("FAIL rst_hold got addr %h v%b r%b want 0 v0 r0", imem_addr, ir_valid, imem_rden); end
    rst = 1'b0; stall = 1'b0; #1;
    checks++; if (imem_rden !== 1'b1) begin errors++; $display("FAIL rst_hold_boot_rden got %b want 1", imem_rden); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (ir_valid !== exp_v[c] || ir !== exp_ir[c]) begin
        errors++; $display("FAIL rst_hold_seq c%0d got %h v%b want %h v%b", c + 5, ir, ir_valid, exp_ir[c], exp_v[c]); end
      tick();
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr0 got %h want fffffff8", w_addr); end
    tick();
    checks++; if (w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1 got %h want fffffffc", w_addr); end
    tick();
    checks++; if (w_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr2 got %h want 0", w_addr); end
    checks++; if (w_ir !== mem_word(32'hFFFF_FFF8) || w_pc_out !== 32'hFFFF_FFF8 || w_ir_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_ir2 got %h@%h v%b want %h@fffffff8 v1", w_ir, w_pc_out, w_ir_valid, mem_word(32'hFFFF_FFF8)); end
    tick();
    checks++; if (w_pc_out !== 32'hFFFF_FFFC || w_pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_plus4 got %h/%h want fffffffc/0", w_pc_out, w_pc_plus4); end
    tick();
    checks++; if (w_ir !== 32'h100 || w_pc_out !== 32'h0 || w_pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL wrap_ir4 got %h@%h/%h want 100@0/4", w_ir, w_pc_out, w_pc_plus4); end
  endtask

  // Random stall/redirect/reset traffic against stream-order rules:
  // valid instructions follow program order from the last redirect/reset target,
  // stalls freeze IF/DE, redirects give exactly two bubbles, no long idle gaps.
  task automatic test_random(input int n);
    logic [31:0] exp_next, last_ir, last_pc, p_tgt, tgt;
    logic        last_valid, p_rst, pp_rst, p_stall, p_redir, pp_redir;
    logic [1:0]  sel;
    int          idle;
    apply_reset();
    p_rst = 1'b1; pp_rst = 1'b0; p_stall = 1'b0; p_redir = 1'b0; pp_redir = 1'b0;
    p_tgt = '0; exp_next = '0; idle = 0;
    last_ir = NOP; last_pc = '0; last_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++; if (pc_plus4 !== pc_out + 32'd4) begin errors++; $display("FAIL rnd_plus4 i%0d got %h want %h", i, pc_plus4, pc_out + 32'd4); end
      if (ir_valid === 1'b0) begin
        checks++; if (ir !== NOP) begin errors++; $display("FAIL rnd_bubble_ir i%0d got %h want %h", i, ir, NOP); end
      end
      if (p_rst) begin
        checks++; if (ir !== NOP || ir_valid !== 1'b0 || pc_out !== 32'h0) begin
          errors++; $display("FAIL rnd_reset i%0d got %h@%h v%b want %h@0 v0", i, ir, pc_out, ir_valid, NOP); end
        exp_next = 32'h0; idle = 0;
      end else if (p_redir) begin
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rnd_redir_bubble i%0d got %b want 0", i, ir_valid); end
        checks++; if (imem_addr !== {p_tgt[31:2], 2'b00}) begin errors++; $display("FAIL rnd_redir_addr i%0d got %h want %h", i, imem_addr, {p_tgt[31:2], 2'b00}); end
        exp_next = {p_tgt[31:2], 2'b00}; idle = 0;
      end else if (p_stall && !pp_rst) begin
        checks++; if (ir !== last_ir || pc_out !== last_pc || ir_valid !== last_valid) begin
          errors++; $display("FAIL rnd_stall_hold i%0d got %h@%h v%b want %h@%h v%b", i, ir, pc_out, ir_valid, last_ir, last_pc, last_valid); end
        idle = 0;
      end else begin
        if (pp_redir || pp_rst) begin
          checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rnd_second_bubble i%0d got %b want 0", i, ir_valid); end
        end
        if (ir_valid === 1'b1) begin
          checks++; if (pc_out !== exp_next) begin errors++; $display("FAIL rnd_order i%0d got %h want %h", i, pc_out, exp_next); end
          checks++; if (ir !== mem_word(pc_out)) begin errors++; $display("FAIL rnd_data i%0d got %h want %h", i, ir, mem_word(pc_out)); end
          exp_next = exp_next + 32'd4; idle = 0;
        end else begin
          idle++;
          checks++; if (idle >= 2) begin errors++; $display("FAIL rnd_starve i%0d got %0d idle want <2", i, idle); end
        end
      end
      last_ir = ir; last_pc = pc_out; last_valid = ir_valid;

      rst   = ($urandom_range(0, 99) < 1);
      stall = ($urandom_range(0, 99) < 25);
      sel   = ($urandom_range(0, 99) < 8) ? 2'($urandom_range(1, 3)) : 2'd0;
      pc_sel = sel;
      jalr_tgt = $urandom; branch_tgt = $urandom; jal_tgt = $urandom;
      tgt = (sel == 2'd1) ? jalr_tgt : (sel == 2'd2) ? branch_tgt : jal_tgt;
      #1;
      if (rst) begin
        checks++; if (imem_rden !== 1'b0) begin errors++; $display("FAIL rnd_rst_rden i%0d got %b want 0", i, imem_rden); end
      end else if (p_rst) begin
        checks++; if (imem_rden !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rnd_boot i%0d got %h r%b want 0 r1", i, imem_addr, imem_rden); end
      end else if (stall) begin
        checks++; if (imem_rden !== 1'b0) begin errors++; $display("FAIL rnd_stall_rden i%0d got %b want 0", i, imem_rden); end
      end
      pp_rst = p_rst; pp_redir = p_redir;
      p_rst = rst; p_stall = stall; p_redir = (sel != 2'd0); p_tgt = tgt;
      tick();
    end
    rst = 1'b0; drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_boot_seq();
    test_stall();
    test_redirect_jal();
    test_hold_redirect();
    test_reset_in_hold();
    test_wrap();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
